stage1_fetch: RTL and testbench

Instruction-fetch stage (stage 1) of the 5-stage 8-bit pipelined processor. It owns the 12-bit PC, issues requests to instruction memory over a req/ack handshake and fills the IF/ID register that feeds stage 2. It honours stage-2 stalls and takes redirects (branch, jump, return) from stage 2. On every redirect or memory wait it injects the controller NOP word into IF/ID.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/stage1_fetch_if.sv | 24 ++
 rtl/stage1_fetch_pc_next_gen.sv | 35 +++
 rtl/stage1_fetch.sv | 97 +++++++++
 tb/tb_stage1_fetch.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined 8-bit CPU: NOP word, next-PC select codes,
// fetch FSM states and default widths.
package cpu_pkg;

    localparam int PC_W_DEF    = 12;
    localparam int INSTR_W_DEF = 19;

    // Same word stage 2 injects for stall bubbles.
    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = {6'b111101, 13'd0};

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;
    localparam logic [1:0] PC_RET = 2'b11;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_FETCH = 2'd1,
        S_REDIR = 2'd2
    } fetchState_e;

endpackage

// File: rtl/stage1_fetch_if.sv
// Instruction-memory req/ack bus between the fetch stage (master) and imem (slave).
interface stage1_fetch_if #(
    parameter int PC_W    = 12,
    parameter int INSTR_W = 19
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_data
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_data
    );
endinterface

// File: rtl/stage1_fetch_pc_next_gen.sv
// Redirect target mux and branch adder for the fetch stage; also supplies pc+1.
module pc_next_gen
    import cpu_pkg::*;
#(
    parameter int PC_W = PC_W_DEF
) (
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] idPc,
    input  logic [1:0]      pcInputSel,
    input  logic            pcAdderInputASel,
    input  logic [7:0]      const_disp,
    input  logic [PC_W-1:0] jump_target,
    input  logic [PC_W-1:0] stackOut,
    output logic [PC_W-1:0] redirTarget,
    output logic [PC_W-1:0] pcInc
);

    logic [PC_W-1:0] adderBase;
    logic [PC_W-1:0] dispExt;

    assign adderBase = pcAdderInputASel ? idPc : pc;
    assign dispExt   = {{(PC_W-8){const_disp[7]}}, const_disp};
    assign pcInc     = pc + PC_W'(1);

    always_comb begin
        redirTarget = pc;
        unique case (pcInputSel)
            PC_BR:   redirTarget = adderBase + dispExt;
            PC_JMP:  redirTarget = jump_target;
            PC_RET:  redirTarget = stackOut;
            default: redirTarget = pc;
        endcase
    end

endmodule

// File: rtl/stage1_fetch.sv
// Instruction-fetch stage: owns the PC, drives the imem req/ack bus and fills IF/ID.
//
// state   | meaning
// S_RESET | first cycle after reset, no request, redirects ignored
// S_FETCH | requesting imem at pc
// S_REDIR | one dead cycle after a redirect, cancels any in-flight access
module stage1_fetch
    import cpu_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sstall,
    input  logic [1:0]          pcInputSel,
    input  logic                pcAdderInputASel,
    input  logic [7:0]          const_disp,
    input  logic [PC_W-1:0]     jump_target,
    input  logic [PC_W-1:0]     stackOut,
    stage1_fetch_if.master      imem,
    output logic [INSTR_W-1:0]  instruction,
    output logic [PC_W-1:0]     id_pc,
    output logic [PC_W-1:0]     stackIn,
    output logic                fetch_busy
);

    fetchState_e     state, stateNext;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] redirTarget;
    logic [PC_W-1:0] pcInc;
    logic            redirect;
    logic            fetchReq;

    pc_next_gen #(.PC_W(PC_W)) uNextGen (
        .pc               (pc),
        .idPc             (id_pc),
        .pcInputSel       (pcInputSel),
        .pcAdderInputASel (pcAdderInputASel),
        .const_disp       (const_disp),
        .jump_target      (jump_target),
        .stackOut         (stackOut),
        .redirTarget      (redirTarget),
        .pcInc            (pcInc)
    );

    assign redirect = (state != S_RESET) && (pcInputSel != PC_SEQ);

    always_comb begin
        stateNext = state;
        fetchReq  = 1'b0;
        unique case (state)
            S_RESET: stateNext = S_FETCH;
            S_FETCH: begin
                fetchReq  = 1'b1;
                stateNext = redirect ? S_REDIR : S_FETCH;
            end
            S_REDIR: stateNext = redirect ? S_REDIR : S_FETCH;
            default: stateNext = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_RESET;
        end else begin
            state <= stateNext;
        end
    end

    // Priority: redirect > stall > ack; a redirect discards any same-cycle ack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= '0;
            instruction <= INSTR_W'(NOP_INSTR);
            id_pc       <= '0;
        end else if (redirect) begin
            pc          <= redirTarget;
            instruction <= INSTR_W'(NOP_INSTR);
            id_pc       <= redirTarget;
        end else if (state == S_FETCH && !sstall) begin
            if (imem.imem_ack) begin
                instruction <= imem.imem_data;
                id_pc       <= pc;
                pc          <= pcInc;
            end else begin
                instruction <= INSTR_W'(NOP_INSTR);
            end
        end
    end

    assign imem.imem_req  = fetchReq;
    assign imem.imem_addr = pc;
    assign fetch_busy     = fetchReq & ~imem.imem_ack;
    assign stackIn        = id_pc + PC_W'(1);

endmodule

// File: tb/tb_stage1_fetch.sv
// Randomized scoreboard bench for stage1_fetch against a behavioural fetch model.
module tb_stage1_fetch;

    localparam int NRAND = 2500;
    localparam logic [18:0] NOP = {6'b111101, 13'd0};

    logic        clk = 1'b0;
    logic        rst;
    logic        sstall;
    logic [1:0]  pcInputSel;
    logic        pcAdderInputASel;
    logic [7:0]  const_disp;
    logic [11:0] jump_target;
    logic [11:0] stackOut;
    logic [18:0] instruction;
    logic [11:0] id_pc;
    logic [11:0] stackIn;
    logic        fetch_busy;

    stage1_fetch_if #(.PC_W(12), .INSTR_W(19)) bus ();

    stage1_fetch #(.PC_W(12), .INSTR_W(19)) dut (
        .clk              (clk),
        .rst              (rst),
        .sstall           (sstall),
        .pcInputSel       (pcInputSel),
        .pcAdderInputASel (pcAdderInputASel),
        .const_disp       (const_disp),
        .jump_target      (jump_target),
        .stackOut         (stackOut),
        .imem             (bus.master),
        .instruction      (instruction),
        .id_pc            (id_pc),
        .stackIn          (stackIn),
        .fetch_busy       (fetch_busy)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFail   = 0;
    bit done    = 1'b0;

    // {req, busy, addr}
    logic [13:0] reqQ[$];
    // {instruction, id_pc, stackIn}
    logic [42:0] ifidQ[$];

    // Reference model: PC plus "just reset" / "cancel cycle" flags.
    int  mPc, mIdPc;
    logic [18:0] mInstr;
    bit  mJustReset, mCancel;

    function automatic logic [18:0] memWord(input logic [11:0] a);
        return {a[6:0] ^ 7'h55, a};
    endfunction

    function automatic int wrap12(input int v);
        return ((v % 4096) + 4096) % 4096;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit st, input logic [1:0] sel, input bit asel,
                         input logic [7:0] disp, input logic [11:0] jt, input logic [11:0] so,
                         input bit ack);
        bit req;
        int d, tgt;
        @(negedge clk);
        rst              = r;
        sstall           = st;
        pcInputSel       = sel;
        pcAdderInputASel = asel;
        const_disp       = disp;
        jump_target      = jt;
        stackOut         = so;
        bus.imem_ack     = ack;
        bus.imem_data    = ack ? memWord(bus.imem_addr) : 19'h7FFFF;

        req = !mJustReset && !mCancel;
        reqQ.push_back({req, req && !ack, 12'(mPc)});

        if (!r) begin
            mPc = 0; mIdPc = 0; mInstr = NOP; mJustReset = 1; mCancel = 0;
        end else if (mJustReset) begin
            mJustReset = 0;
        end else if (sel != 2'b00) begin
            d = (disp >= 128) ? int'(disp) - 256 : int'(disp);
            case (sel)
                2'b01:   tgt = wrap12((asel ? mIdPc : mPc) + d);
                2'b10:   tgt = int'(jt);
                default: tgt = int'(so);
            endcase
            mPc = tgt; mIdPc = tgt; mInstr = NOP; mCancel = 1;
        end else if (mCancel) begin
            mCancel = 0;
        end else if (!st) begin
            if (ack) begin
                mInstr = memWord(12'(mPc));
                mIdPc  = mPc;
                mPc    = wrap12(mPc + 1);
            end else begin
                mInstr = NOP;
            end
        end
        ifidQ.push_back({mInstr, 12'(mIdPc), 12'(wrap12(mIdPc + 1))});
    endtask

    task automatic seq(input int n, input bit ack);
        for (int i = 0; i < n; i++) cycle(1, 0, 2'b00, 0, 8'h00, 12'h0, 12'h0, ack);
    endtask

    initial begin : driver
        rst = 1'b0; sstall = 1'b0; pcInputSel = 2'b00; pcAdderInputASel = 1'b0;
        const_disp = '0; jump_target = '0; stackOut = '0;
        bus.imem_ack = 1'b0; bus.imem_data = '0;
        mPc = 0; mIdPc = 0; mInstr = NOP; mJustReset = 1; mCancel = 0;

        cycle(0, 0, 2'b00, 0, 8'h00, 12'h0, 12'h0, 0);
        cycle(0, 0, 2'b00, 0, 8'h00, 12'h0, 12'h0, 1);
        seq(7, 1);
        seq(2, 0);
        seq(2, 1);
        for (int i = 0; i < 3; i++) cycle(1, 1, 2'b00, 0, 8'h00, 12'h0, 12'h0, 1);
        seq(3, 1);
        cycle(1, 1, 2'b10, 0, 8'h00, 12'h3A7, 12'h0, 1);
        seq(3, 1);
        cycle(1, 1, 2'b11, 0, 8'h00, 12'h0, 12'h123, 1);
        seq(3, 1);
        cycle(1, 0, 2'b01, 1, 8'hFC, 12'h0, 12'h0, 1);
        seq(3, 1);
        cycle(0, 0, 2'b00, 0, 8'h00, 12'h0, 12'h0, 0);
        seq(3, 1);
        cycle(1, 0, 2'b01, 1, 8'hF0, 12'h0, 12'h0, 1);
        seq(3, 1);
        cycle(1, 0, 2'b00, 0, 8'h00, 12'h0, 12'h0, 0);
        cycle(0, 0, 2'b00, 0, 8'h00, 12'h0, 12'h0, 0);
        seq(2, 1);

        for (int i = 0; i < NRAND; i++) begin
            cycle($urandom_range(0, 99) != 0,
                  $urandom_range(0, 4) == 0,
                  ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                  1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)),
                  12'($urandom_range(0, 4095)),
                  12'($urandom_range(0, 4095)),
                  $urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #2;
        done = 1'b1;
    end

    initial begin : monitor
        logic [13:0] er;
        logic [42:0] ei;
        int iter;
        iter = 0;
        while (!(done && reqQ.size() == 0 && ifidQ.size() == 0)) begin
            @(negedge clk);
            #2;
            if (reqQ.size() != 0) begin
                er = reqQ.pop_front();
                check("imem_req", int'(bus.imem_req), int'(er[13]));
                check("fetch_busy", int'(fetch_busy), int'(er[12]));
                if (er[13]) check("imem_addr", int'(bus.imem_addr), int'(er[11:0]));
            end
            @(posedge clk);
            #1;
            if (ifidQ.size() != 0) begin
                ei = ifidQ.pop_front();
                check("instruction", int'(instruction), int'(ei[42:24]));
                check("id_pc", int'(id_pc), int'(ei[23:12]));
                check("stackIn", int'(stackIn), int'(ei[11:0]));
            end
            iter++;
            if (iter > NRAND + 1000) begin
                check("monitor_timeout", iter, 0);
                break;
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
